activation: RTL and testbench
=============================

ACTIVATION -- requirements
Module: activation

Interface
REQ-001 Parameter DWIDTH, default 8, lane width in bits, signed Q5.3 (5 integer bits incl. sign, 3 fractional).
REQ-002 Parameter DESIGN_SIZE, default 16, lanes per beat and beats per tile.
REQ-003 Parameter MASK_WIDTH, default 16, one validity bit per lane.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 enable_activation  input  1  1 = activation applied, 0 = bypass.
REQ-007 activation_type  input  1  0 = ReLU, 1 = piecewise-linear tanh (PWL-tanh).
REQ-008 in_data_available  input  1  inp_data valid this cycle (pooled output beat from upstream pool stage).
REQ-009 inp_data  input  DESIGN_SIZE*DWIDTH  lane k at bits [k*DWIDTH +: DWIDTH].
REQ-010 validity_mask  input  MASK_WIDTH  bit k = 1 marks lane k valid.
REQ-011 out_data  output  DESIGN_SIZE*DWIDTH  activated beat, same lane packing.
REQ-012 out_data_available  output  1  out_data valid this cycle.
REQ-013 done_activation  output  1  tile of DESIGN_SIZE beats fully emitted.

Function
REQ-014 Bypass (enable_activation=0), combinational: out_data=inp_data, out_data_available=in_data_available, done_activation=1.
REQ-015 Enabled: out_data, out_data_available, done_activation driven from registers only.
REQ-016 Enabled pipeline: 2 stages, no stalls, no backpressure; beat accepted in cycle N appears with out_data_available=1 in cycle N+2.
REQ-017 Stage 1 registers inp_data, validity_mask, activation_type and a valid bit on every cycle; valid bit = in_data_available.
REQ-018 Stage 2 computes per-lane result from stage-1 registers; out_data_available = stage-1 valid delayed one cycle.
REQ-019 Gaps in in_data_available propagate as bubbles; out_data holds last value when out_data_available=0.
REQ-020 activation_type travels with its beat; changing it between beats affects only later beats.
REQ-021 ReLU: x<0 -> 0; else x unchanged.
REQ-022 PWL-tanh on m=|x| (computed in DWIDTH+1 bits, so x=-128 gives m=128): m<4 -> y=m; 4<=m<12 -> y=2+(m>>1); m>=12 -> y=8; result = -y if x<0, else y.
REQ-023 PWL-tanh output range -8..8 (-1.0..1.0); result is never wider than DWIDTH, no overflow possible.
REQ-024 Lane with stage-1 mask bit 0 outputs 0 regardless of type.
REQ-025 Beat counter (>= log2(DESIGN_SIZE)+1 bits) increments on each cycle out_data_available=1.
REQ-026 When the DESIGN_SIZE-th output beat is emitted, done_activation goes 1 on the next cycle and the counter clears to 0.
REQ-027 done_activation stays 1 until the first cycle in_data_available=1 of the next tile, then returns to 0 on the following cycle.
REQ-028 If an input beat arrives while done_activation=1, it is counted as beat 1 of the new tile.
REQ-029 enable_activation=0 clears all internal state, like reset; beats in flight are discarded.

Reset
REQ-030 reset=1 clears stage registers, valid bits, counter, out_data, out_data_available and done_activation_temp to 0 on the next edge.
REQ-031 Reset mid-tile discards partial count and in-flight beats; first output after release needs a fresh 2-cycle latency.
REQ-032 While reset=1 with enable_activation=1: out_data=0, out_data_available=0, done_activation=0.

Verification
REQ-033 Bypass: enable=0, inp lane0=0xF0 with in_data_available=1 -> same cycle out lane0=0xF0, out_data_available=1, done_activation=1.
REQ-034 ReLU: type=0, mask=0xFFFF, lanes {-5,0,7,127,-128} -> 2 cycles later {0,0,7,127,0}.
REQ-035 PWL-tanh: type=1, lanes {3,-3,6,-6,11,12,-128,127} -> {3,-3,5,-5,7,8,-8,8}.
REQ-036 Mask: mask=0x00FF, all lanes=20, type=0 -> lanes 0-7 = 20, lanes 8-15 = 0.
REQ-037 Tile/done: 16 beats with 1-cycle gaps after beats 4 and 9 -> 16 outputs, each at input+2; done=1 the cycle after beat-16 output; next tile's first input drops done one cycle later.
REQ-038 Reset mid-tile: reset after 7 beats, then 16 beats -> done only after the 16th post-reset output; no stale outputs appear after reset.

Source files
------------

// File: rtl/activation.sv
// Activation stage: per-lane ReLU or piecewise-linear tanh on signed Q5.3 lanes.
// Two-stage pipeline when enabled, pure combinational pass-through when bypassed.
// Also tracks output beats per tile and raises done_activation after the last beat.
module activation #(
  parameter int DWIDTH      = 8,
  parameter int DESIGN_SIZE = 16,
  parameter int MASK_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable_activation,
  input  logic                          activation_type,
  input  logic                          in_data_available,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
  input  logic [MASK_WIDTH-1:0]         validity_mask,
  output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
  output logic                          out_data_available,
  output logic                          done_activation
);

  localparam int CW = $clog2(DESIGN_SIZE) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(DESIGN_SIZE - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Breakpoints of the tanh approximation, in the widened magnitude domain
  localparam logic [DWIDTH:0] M_LO   = (DWIDTH+1)'(4);
  localparam logic [DWIDTH:0] M_HI   = (DWIDTH+1)'(12);
  localparam logic [DWIDTH:0] Y_OFS  = (DWIDTH+1)'(2);
  localparam logic [DWIDTH:0] Y_SAT  = (DWIDTH+1)'(8);
  localparam logic [DWIDTH:0] M_ONE  = (DWIDTH+1)'(1);
  localparam logic [DWIDTH-1:0] D_ONE = DWIDTH'(1);

  // ReLU: negative lanes clamp to zero
  function automatic logic [DWIDTH-1:0] relu(input logic [DWIDTH-1:0] x);
    logic [DWIDTH-1:0] r;
    if (x[DWIDTH-1]) begin
      r = '0;
    end else begin
      r = x;
    end
    return r;
  endfunction

  // PWL tanh: magnitude is one bit wider so the most negative input is exact
  function automatic logic [DWIDTH-1:0] pwl_tanh(input logic [DWIDTH-1:0] x);
    logic [DWIDTH:0]   m;
    logic [DWIDTH:0]   y;
    logic [DWIDTH-1:0] r;
    if (x[DWIDTH-1]) begin
      m = {1'b0, ~x} + M_ONE;
    end else begin
      m = {1'b0, x};
    end
    if (m < M_LO) begin
      y = m;
    end else if (m < M_HI) begin
      y = Y_OFS + (m >> 1);
    end else begin
      y = Y_SAT;
    end
    // |y| <= 8, so the low DWIDTH bits always hold the full signed result
    if (x[DWIDTH-1]) begin
      r = ~y[DWIDTH-1:0] + D_ONE;
    end else begin
      r = y[DWIDTH-1:0];
    end
    return r;
  endfunction

  // One lane of stage 2: masked lanes output zero regardless of type
  function automatic logic [DWIDTH-1:0] lane_result(input logic [DWIDTH-1:0] x,
                                                    input logic lane_valid,
                                                    input logic use_tanh);
    logic [DWIDTH-1:0] r;
    if (!lane_valid) begin
      r = '0;
    end else if (use_tanh) begin
      r = pwl_tanh(x);
    end else begin
      r = relu(x);
    end
    return r;
  endfunction

  logic [DESIGN_SIZE*DWIDTH-1:0] s1_data_q;
  logic [MASK_WIDTH-1:0]         s1_mask_q;
  logic                          s1_type_q;
  logic                          s1_valid_q;
  logic [DESIGN_SIZE*DWIDTH-1:0] out_data_q, out_data_d;
  logic                          out_valid_q;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          done_q, done_d;
  logic [DESIGN_SIZE*DWIDTH-1:0] lane_res;
  logic                          clear;

  // Bypass mode flushes everything exactly like reset
  assign clear = reset | ~enable_activation;

  // Stage-2 datapath: activate every lane of the stage-1 beat
  always_comb begin
    lane_res = '0;
    for (int k = 0; k < DESIGN_SIZE; k++) begin
      lane_res[k*DWIDTH +: DWIDTH] = lane_result(s1_data_q[k*DWIDTH +: DWIDTH],
                                                 s1_mask_q[k], s1_type_q);
    end
  end

  // Next-state for output register and tile bookkeeping
  always_comb begin
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    if (s1_valid_q) begin
      out_data_d = lane_res;
    end else begin
      out_data_d = out_data_q;
    end
    if (out_valid_q && (cnt_q == LAST_BEAT)) begin
      cnt_d  = '0;
      done_d = 1'b1;
    end else begin
      if (out_valid_q) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
      // First input of the next tile retires the done flag
      if (done_q && in_data_available) begin
        done_d = 1'b0;
      end else begin
        done_d = done_q;
      end
    end
  end

  // Pipeline and tile-state registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clear) begin
      s1_data_q   <= '0;
      s1_mask_q   <= '0;
      s1_type_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      s1_data_q   <= inp_data;
      s1_mask_q   <= validity_mask;
      s1_type_q   <= activation_type;
      s1_valid_q  <= in_data_available;
      out_data_q  <= out_data_d;
      out_valid_q <= s1_valid_q;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

  // Output select: registered pipeline when enabled, straight wires in bypass
  always_comb begin
    if (enable_activation) begin
      out_data           = out_data_q;
      out_data_available = out_valid_q;
      done_activation    = done_q;
    end else begin
      out_data           = inp_data;
      out_data_available = in_data_available;
      done_activation    = 1'b1;
    end
  end

endmodule

// File: tb/tb_activation.sv
// Scoreboard bench for activation: stimulus pushes expected beats with their
// due cycle; a negedge monitor pops and compares whenever an output is valid.
module tb_activation;

  logic         clk;
  logic         reset;
  logic         enable_activation;
  logic         activation_type;
  logic         in_data_available;
  logic [127:0] inp_data;
  logic [15:0]  validity_mask;
  logic [127:0] out_data;
  logic         out_data_available;
  logic         done_activation;

  typedef struct {
    logic [127:0] d;
    int           c;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;

  activation dut (
    .clk                (clk),
    .reset              (reset),
    .enable_activation  (enable_activation),
    .activation_type    (activation_type),
    .in_data_available  (in_data_available),
    .inp_data           (inp_data),
    .validity_mask      (validity_mask),
    .out_data           (out_data),
    .out_data_available (out_data_available),
    .done_activation    (done_activation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: every valid output must match the oldest outstanding beat, on time
  always @(negedge clk) begin
    if (mon_en && enable_activation && out_data_available) begin
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL stale_output: got %h expected no output (cycle %0d)", out_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("beat_data", out_data, e.d);
        chk("beat_latency", 128'(cyc), 128'(e.c));
      end
    end
  end

  // Drive one beat (called just after a rising edge) and book its expectation
  task automatic beat(input logic [127:0] d, input logic [15:0] m, input logic t,
                      input logic [127:0] e);
    exp_t x;
    inp_data          = d;
    validity_mask     = m;
    activation_type   = t;
    in_data_available = 1'b1;
    x.d = e;
    x.c = cyc + 2;
    sb.push_back(x);
    @(posedge clk); #1;
    in_data_available = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Beats first..last, every lane = i + base (positive, so ReLU passes it)
  task automatic send_run(input int first, input int last, input int gap_a,
                          input int gap_b, input int base);
    for (int i = first; i <= last; i++) begin
      logic [7:0] v;
      v = 8'(i + base);
      beat({16{v}}, 16'hFFFF, 1'b0, {16{v}});
      chk("done_mid_tile", 128'(done_activation), 128'(0));
      if (i == gap_a || i == gap_b) idle(1);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable_activation = 1'b1;
    activation_type = 1'b0;
    in_data_available = 1'b0;
    inp_data = '0;
    validity_mask = 16'hFFFF;

    // Reset state
    idle(2);
    @(negedge clk);
    chk("rst_avail", 128'(out_data_available), 128'(0));
    chk("rst_done", 128'(done_activation), 128'(0));
    chk("rst_data", out_data, 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // ReLU: {-5,0,7,127,-128} -> {0,0,7,127,0}
    beat({88'h0, 8'h80, 8'h7F, 8'h07, 8'h00, 8'hFB}, 16'hFFFF, 1'b0,
         {88'h0, 8'h00, 8'h7F, 8'h07, 8'h00, 8'h00});
    // PWL-tanh: {3,-3,6,-6,11,12,-128,127} -> {3,-3,5,-5,7,8,-8,8}
    beat({64'h0, 8'h7F, 8'h80, 8'h0C, 8'h0B, 8'hFA, 8'h06, 8'hFD, 8'h03}, 16'hFFFF, 1'b1,
         {64'h0, 8'h08, 8'hF8, 8'h08, 8'h07, 8'hFB, 8'h05, 8'hFD, 8'h03});
    // Mask: lanes 8-15 invalid
    beat({16{8'h14}}, 16'h00FF, 1'b0, {{8{8'h00}}, {8{8'h14}}});
    // Bubble: output holds the last beat
    idle(3);
    @(negedge clk);
    chk("bubble_avail", 128'(out_data_available), 128'(0));
    chk("bubble_hold", out_data, {{8{8'h00}}, {8{8'h14}}});
    chk("partial_done", 128'(done_activation), 128'(0));
    @(posedge clk); #1;

    // Fresh tile: 16 beats with gaps after beats 4 and 9
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    send_run(1, 16, 4, 9, 0);
    @(negedge clk);
    chk("done_before_last_out", 128'(done_activation), 128'(0));
    @(negedge clk);
    chk("done_at_last_out", 128'(done_activation), 128'(0));
    @(negedge clk);
    chk("done_after_last_out", 128'(done_activation), 128'(1));
    @(negedge clk);
    chk("done_holds", 128'(done_activation), 128'(1));
    @(posedge clk); #1;
    chk("done_before_next_in", 128'(done_activation), 128'(1));
    beat({16{8'h21}}, 16'hFFFF, 1'b0, {16{8'h21}});
    chk("done_drops", 128'(done_activation), 128'(0));
    send_run(2, 7, 0, 0, 32);

    // Mid-tile reset: beat 7 is still in flight and must vanish
    reset = 1'b1;
    @(negedge clk); #1;
    sb.delete();
    @(negedge clk);
    chk("midrst_avail", 128'(out_data_available), 128'(0));
    chk("midrst_done", 128'(done_activation), 128'(0));
    chk("midrst_data", out_data, 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    send_run(1, 16, 0, 0, 64);
    @(negedge clk);
    chk("rst_tile_done_early", 128'(done_activation), 128'(0));
    @(negedge clk);
    chk("rst_tile_done_last", 128'(done_activation), 128'(0));
    @(negedge clk);
    chk("rst_tile_done", 128'(done_activation), 128'(1));
    idle(2);
    chk("sb_drained", 128'(sb.size()), 128'(0));

    // Bypass: combinational pass-through
    mon_en = 1'b0;
    enable_activation = 1'b0;
    inp_data = {120'h0, 8'hF0};
    in_data_available = 1'b1;
    #1;
    chk("byp_data", out_data, {120'h0, 8'hF0});
    chk("byp_avail", 128'(out_data_available), 128'(1));
    chk("byp_done", 128'(done_activation), 128'(1));
    @(posedge clk); #1;
    in_data_available = 1'b0;
    enable_activation = 1'b1;
    @(negedge clk);
    chk("reen_avail", 128'(out_data_available), 128'(0));
    chk("reen_done", 128'(done_activation), 128'(0));
    chk("reen_data", out_data, 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
